// File: rtl/hd_bus_port.sv
// Half-duplex controller for a row of tri-state pad buffers: turns core write/read
// requests into drive / high-Z turnaround / sample sequences on a shared bus.
module hd_bus_port #(
  parameter int WIDTH       = 8,
  parameter int HOLD        = 2,
  parameter int TURN        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WR_REQ,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             WR_ACK,
  input  logic             RD_REQ,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic             BUSY,
  output logic [WIDTH-1:0] PAD_I,
  output logic [WIDTH-1:0] PAD_T,
  input  logic [WIDTH-1:0] PAD_O
);

  localparam int CMAX_HT = (HOLD > TURN) ? HOLD : TURN;
  localparam int CMAX    = (CMAX_HT > SYNC_STAGES) ? CMAX_HT : SYNC_STAGES;
  localparam int CW      = $clog2(CMAX + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN - 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_STAGES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN, S_SAMPLE} state_t;

  state_t                              state_q, state_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic [WIDTH-1:0]                    pad_i_q, pad_i_d;
  logic [WIDTH-1:0]                    pad_t_q, pad_t_d;
  logic [WIDTH-1:0]                    rd_data_q, rd_data_d;
  logic                                wr_ack_q, wr_ack_d;
  logic                                rd_valid_q, rd_valid_d;
  logic                                busy_q, busy_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q, sync_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pad_i_d    = pad_i_q;
    rd_data_d  = rd_data_q;
    wr_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    sync_d     = {sync_q[SYNC_STAGES-2:0], PAD_O};

    case (state_q)
      S_IDLE: begin
        // Reads win a tie so a pending sample is never delayed by a full write cycle.
        if (RD_REQ) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
        end else if (WR_REQ) begin
          state_d  = S_DRIVE;
          cnt_d    = '0;
          pad_i_d  = WR_DATA;
          wr_ack_d = (HOLD == 1);
        end
      end
      S_DRIVE: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_TURN;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          wr_ack_d = (cnt_d == HOLD_LAST);
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == SYNC_LAST) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          rd_data_d  = sync_q[SYNC_STAGES-1];
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Enables and BUSY are registered from the next state so the pads see clean flop outputs.
    pad_t_d = {WIDTH{state_d != S_DRIVE}};
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pad_i_q    <= '0;
      pad_t_q    <= '1;
      rd_data_q  <= '0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pad_i_q    <= pad_i_d;
      pad_t_q    <= pad_t_d;
      rd_data_q  <= rd_data_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      sync_q     <= sync_d;
    end
  end

  assign PAD_I    = pad_i_q;
  assign PAD_T    = pad_t_q;
  assign RD_DATA  = rd_data_q;
  assign WR_ACK   = wr_ack_q;
  assign RD_VALID = rd_valid_q;
  assign BUSY     = busy_q;

endmodule
